// File: rtl/xor_cipher_key_sequencer_if.sv
// Key-load and cipher-chain bundle for xor_cipher_key_sequencer.
// The sequencer uses the slave modport; the key source / cipher side uses master.
interface xor_cipher_key_sequencer_if;
    logic [7:0] key_byte;
    logic       key_valid;
    logic       key_ready;
    logic       tx_req;
    logic       rx_req;
    logic       cfg_o;
    logic       cfg_en;
    logic       cfg_i;
    logic       tx_en;
    logic       rx_en;
    logic       key_ok;
    logic       busy;
    logic       err;

    modport master (
        output key_byte, key_valid, tx_req, rx_req, cfg_o,
        input  key_ready, cfg_en, cfg_i, tx_en, rx_en, key_ok, busy, err
    );

    modport slave (
        input  key_byte, key_valid, tx_req, rx_req, cfg_o,
        output key_ready, cfg_en, cfg_i, tx_en, rx_en, key_ok, busy, err
    );
endinterface

// File: rtl/xor_cipher_key_sequencer.sv
// Collects an M-bit key bytewise and shifts it MSB-first into the cipher config chain.
// Build option KEY_SEQ_VERIFY_EN adds a readback pass that checks the chain contents.
module xor_cipher_key_sequencer #(
    parameter int M = 32
) (
    input logic                       clk,
    input logic                       rst_n,
    xor_cipher_key_sequencer_if.slave bus
);
    localparam int NB = M / 8;
    localparam int CW = $clog2(M) + 1;
    localparam int IW = $clog2(M);
    localparam int BW = $clog2(NB) + 1;

`ifdef KEY_SEQ_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, COLLECT = 3'd1, SHIFT = 3'd2, RUN = 3'd3, VERIFY = 3'd4, ERROR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, COLLECT = 3'd1, SHIFT = 3'd2, RUN = 3'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    key_q, key_d;
    logic            cfg_en_q, cfg_i_q, key_ok_q, key_ready_q, busy_q;
    logic            accept_s, last_bit_s, busy_d_s;
    logic [BW-1:0]   nb_next_s;
    logic [IW-1:0]   idx_q_s, idx_d_s;
`ifdef KEY_SEQ_VERIFY_EN
    logic            mis_q, mis_d, err_q, bit_mis_s;
`else
    logic            unused_cfg_o_s;
`endif

    // Bit position of the key currently on the chain: counter k selects key[M-1-k].
    assign idx_q_s = IW'(M - 1) - cnt_q[IW-1:0];
    assign idx_d_s = IW'(M - 1) - cnt_d[IW-1:0];

`ifdef KEY_SEQ_VERIFY_EN
    assign busy_d_s = (state_d == SHIFT) || (state_d == VERIFY);
`else
    assign busy_d_s = (state_d == SHIFT);
`endif

    // Next-state logic: byte intake, shift pass and optional readback pass.
    always_comb begin
        accept_s   = bus.key_valid && key_ready_q;
        nb_next_s  = ((state_q == COLLECT) ? bcnt_q : {BW{1'b0}}) + BW'(1);
        last_bit_s = (cnt_q == CW'(M - 1));
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
`ifdef KEY_SEQ_VERIFY_EN
        mis_d      = mis_q;
        bit_mis_s  = 1'b0;
`endif
        if (accept_s) begin
            key_d = M'({key_q, bus.key_byte});
            if (nb_next_s == BW'(NB)) begin
                state_d = SHIFT;
                bcnt_d  = {BW{1'b0}};
                cnt_d   = {CW{1'b0}};
`ifdef KEY_SEQ_VERIFY_EN
                mis_d   = 1'b0;
`endif
            end else begin
                state_d = COLLECT;
                bcnt_d  = nb_next_s;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (last_bit_s) begin
                        cnt_d   = {CW{1'b0}};
`ifdef KEY_SEQ_VERIFY_EN
                        state_d = VERIFY;
`else
                        state_d = RUN;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef KEY_SEQ_VERIFY_EN
                VERIFY: begin
                    // Chain MSB in readback cycle k must equal the bit sent in shift cycle k.
                    bit_mis_s = (bus.cfg_o != key_q[idx_q_s]);
                    mis_d     = mis_q | bit_mis_s;
                    if (last_bit_s) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = mis_d ? ERROR : RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ERROR: state_d = ERROR;
`endif
                IDLE, COLLECT, RUN: state_d = state_q;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs; outputs are decoded from next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcnt_q      <= {BW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            key_q       <= {M{1'b0}};
            cfg_en_q    <= 1'b0;
            cfg_i_q     <= 1'b0;
            key_ok_q    <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef KEY_SEQ_VERIFY_EN
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            cfg_en_q    <= busy_d_s;
            cfg_i_q     <= busy_d_s ? key_d[idx_d_s] : 1'b0;
            key_ok_q    <= (state_q == RUN) && (state_d == RUN);
            key_ready_q <= !busy_d_s;
            busy_q      <= busy_d_s;
`ifdef KEY_SEQ_VERIFY_EN
            mis_q       <= mis_d;
            err_q       <= (state_d == ERROR);
`endif
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.cfg_en    = cfg_en_q;
    assign bus.cfg_i     = cfg_i_q;
    assign bus.key_ok    = key_ok_q;
    assign bus.busy      = busy_q;
    assign bus.tx_en     = bus.tx_req & key_ok_q;
    assign bus.rx_en     = bus.rx_req & key_ok_q;
`ifdef KEY_SEQ_VERIFY_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
    assign unused_cfg_o_s = bus.cfg_o;
`endif
endmodule

// File: tb/tb_xor_cipher_key_sequencer.sv
// Bench for xor_cipher_key_sequencer: vector table of key loads plus hand-written
// re-key, back-to-back byte, mid-shift reset and readback-error sequences.
module tb_xor_cipher_key_sequencer;
    localparam int M = 32;
`ifdef KEY_SEQ_VERIFY_EN
    localparam int LAT    = 2 * M + 1;
    localparam int EN_CYC = 2 * M;
`else
    localparam int LAT    = M + 1;
    localparam int EN_CYC = M;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xor_cipher_key_sequencer_if bus();
    xor_cipher_key_sequencer #(.M(M)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Cipher chain model: shifts cfg_i in at the LSB, presents its MSB on cfg_o.
    logic [M-1:0] chain      = {M{1'b0}};
    logic [M-1:0] shift_word = {M{1'b0}};
    int           en_cnt     = 0;
    int           en_total   = 0;
    int           err_cycles = 0;
    logic         fault      = 1'b0;

    always @(posedge clk) begin
        if (bus.cfg_en) begin
            chain <= {chain[M-2:0], bus.cfg_i};
            if (en_cnt == M - 1) shift_word <= {chain[M-2:0], bus.cfg_i};
            en_cnt   <= en_cnt + 1;
            en_total <= en_total + 1;
        end else begin
            en_cnt <= 0;
        end
        if (bus.err) err_cycles <= err_cycles + 1;
    end

    assign bus.cfg_o = chain[M-1] ^ (fault && (en_cnt == M + 5));

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic        tx, rx;
        logic [31:0] word;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.key_byte  = b;
        bus.key_valid = 1'b1;
        while (!bus.key_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_byte_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_key_ok(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.key_ok && n < 400);
    endtask

    initial begin
        int lat;
        int e0;
        vecs[0] = '{8'hA5, 8'hC3, 8'h0F, 8'h96, 1'b1, 1'b0, 32'hA5C30F96};
        vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b1, 32'h12345678};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'h00000000};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 32'hFFFFFFFF};

        bus.key_byte  = 8'h00;
        bus.key_valid = 1'b0;
        bus.tx_req    = 1'b1;
        bus.rx_req    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", bus.key_ready, 32'd1);
        chk("rst_cfg_en", bus.cfg_en, 32'd0);
        chk("rst_cfg_i", bus.cfg_i, 32'd0);
        chk("rst_key_ok", bus.key_ok, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_err", bus.err, 32'd0);
        chk("rst_tx_en", bus.tx_en, 32'd0);
        chk("rst_rx_en", bus.rx_en, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            bus.tx_req = vecs[i].tx;
            bus.rx_req = vecs[i].rx;
            e0 = en_total;
            load4(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            chk("v_busy_after_load", bus.busy, 32'd1);
            chk("v_ready_after_load", bus.key_ready, 32'd0);
            chk("v_tx_gated", bus.tx_en, 32'd0);
            wait_key_ok(lat);
            chk("v_latency", 32'(lat), 32'(LAT));
            chk("v_shift_word", shift_word, vecs[i].word);
            chk("v_chain", chain, vecs[i].word);
            chk("v_cfg_en_cycles", 32'(en_total - e0), 32'(EN_CYC));
            chk("v_tx_en", bus.tx_en, {31'd0, vecs[i].tx});
            chk("v_rx_en", bus.rx_en, {31'd0, vecs[i].rx});
            chk("v_err", bus.err, 32'd0);
            chk("v_key_ready", bus.key_ready, 32'd1);
            chk("v_busy_idle", bus.busy, 32'd0);
        end

        // Re-key from RUN: traffic gated from the cycle after the first byte.
        bus.tx_req = 1'b1;
        bus.rx_req = 1'b0;
        #1;
        chk("rk_tx_en_run", bus.tx_en, 32'd1);
        chk("rk_rx_en_run", bus.rx_en, 32'd0);
        send_byte(8'h11);
        chk("rk_tx_dropped", bus.tx_en, 32'd0);
        chk("rk_key_ok_dropped", bus.key_ok, 32'd0);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("rk_tx_still_gated", bus.tx_en, 32'd0);
        wait_key_ok(lat);
        chk("rk_latency", 32'(lat), 32'(LAT));
        chk("rk_word", shift_word, 32'h11223344);
        chk("rk_tx_back", bus.tx_en, 32'd1);

        // key_valid held high with 01..08: only the first four are taken.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.key_byte  = 8'(i);
            bus.key_valid = 1'b1;
            @(posedge clk);
        end
        #1;
        bus.key_valid = 1'b0;
        chk("bb_busy", bus.busy, 32'd1);
        wait_key_ok(lat);
        chk("bb_latency", 32'(lat), 32'(LAT - 4));
        chk("bb_word", shift_word, 32'h01020304);
        chk("bb_chain", chain, 32'h01020304);

        // Asynchronous reset in SHIFT cycle 10.
        load4(8'hCA, 8'hFE, 8'hBA, 8'hBE);
        repeat (9) @(posedge clk);
        #3;
        chk("ar_cfg_en_before", bus.cfg_en, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_cfg_en", bus.cfg_en, 32'd0);
        chk("ar_busy", bus.busy, 32'd0);
        chk("ar_key_ok", bus.key_ok, 32'd0);
        chk("ar_key_ready", bus.key_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        load4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        wait_key_ok(lat);
        chk("ar_latency", 32'(lat), 32'(LAT));
        chk("ar_word", chain, 32'hDEADBEEF);

`ifdef KEY_SEQ_VERIFY_EN
        // Readback bit 5 corrupted: ERROR, then a new byte clears err.
        bus.tx_req = 1'b1;
        fault = 1'b1;
        load4(8'hA5, 8'hC3, 8'h0F, 8'h96);
        lat = 0;
        while (!bus.err && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("er_err", bus.err, 32'd1);
        chk("er_key_ok", bus.key_ok, 32'd0);
        chk("er_tx_en", bus.tx_en, 32'd0);
        chk("er_key_ready", bus.key_ready, 32'd1);
        fault = 1'b0;
        send_byte(8'h00);
        chk("er_err_cleared", bus.err, 32'd0);
        chk("er_key_ready_after", bus.key_ready, 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_key_ok(lat);
        chk("er_reload_latency", 32'(lat), 32'(LAT));
`else
        chk("nv_err_never_set", 32'(err_cycles), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
